pio_hsimple_master: RTL and testbench

Host-side initiator for the programmed-I/O register file of a Kiwi-generated slave. It accepts read/write commands on a valid/ready command channel and converts each one into a single HSIMPLE req/ack transaction on the slave's `pioRegfileRead_*` or `pioRegfileWrite_*` port pair. It returns one response per command on a valid/ready response channel. Unlike a bare test driver, it bounds every transaction with a timeout and reports failures as errors. It sits directly upstream of the DUT's PIO ports, between the host/bus bridge and the slave.

---
 rtl/pio_hsimple_pkg.sv | 21 ++
 rtl/hsimple_timeout_ctr.sv | 31 +++
 rtl/pio_hsimple_master.sv | 152 +++++++++++++++
 tb/tb_pio_hsimple_master.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pio_hsimple_pkg.sv
// pio_hsimple_pkg
// Shared types and constants for the PIO HSIMPLE master.
//   pioState_e : master FSM states
//   ADDR_W     : PIO address width
//   DATA_W     : PIO data width
//   ERR_RDATA  : read data returned on writes and on timed-out transactions
package pio_hsimple_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_RDATA = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WREQ = 2'd1,
    RREQ = 2'd2,
    RSP  = 2'd3
  } pioState_e;

endpackage

// File: rtl/hsimple_timeout_ctr.sv
// hsimple_timeout_ctr
// Counts cycles spent in a request state and flags when LIMIT is reached.
//   clk     : clock, rising edge
//   reset   : asynchronous active-low reset
//   clear   : synchronous clear (command accept)
//   enable  : count this cycle (master is in WREQ/RREQ)
//   expired : count has reached LIMIT
module hsimple_timeout_ctr #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIM = 16'(LIMIT);

  logic [15:0] count;

  // Holds at LIMIT so a stalled enable can never wrap back through zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 count <= '0;
    else if (clear)             count <= '0;
    else if (enable && !expired) count <= count + 16'd1;
  end

  assign expired = (count == LIM);

endmodule

// File: rtl/pio_hsimple_master.sv
// pio_hsimple_master
// Host-side initiator for a Kiwi PIO register file. Each command on the
// cmd channel becomes one HSIMPLE req/ack transaction on the read or write
// port pair; exactly one response is returned per command. Transactions
// that see no ack within TIMEOUT_CYCLES req-high cycles are abandoned and
// reported with rsp_error, and counted in err_count (saturating).
//   clk, reset                   : clock, async active-low reset
//   cmd_valid/ready/write/addr/wdata : command channel
//   rsp_valid/ready/rdata/write/error : response channel
//   pioRegfileRead_*             : HSIMPLE read port to the slave
//   pioRegfileWrite_*            : HSIMPLE write port to the slave
//   busy                         : FSM not idle
//   err_count                    : timeouts since reset
module pio_hsimple_master
  import pio_hsimple_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERRW           = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              rsp_error,

  output logic [ADDR_W-1:0] pioRegfileRead_addr,
  output logic              pioRegfileRead_req,
  input  logic              pioRegfileRead_ack,
  input  logic [DATA_W-1:0] pioRegfileRead_return,

  output logic [ADDR_W-1:0] pioRegfileWrite_addr,
  output logic [DATA_W-1:0] pioRegfileWrite_data,
  output logic              pioRegfileWrite_req,
  input  logic              pioRegfileWrite_ack,

  output logic              busy,
  output logic [ERRW-1:0]   err_count
);

  pioState_e state;
  logic      accept;
  logic      expired;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid && cmd_ready;

  hsimple_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) uTimeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (state == WREQ || state == RREQ),
    .expired (expired)
  );

  // The first cycle of WREQ/RREQ only launches req (req rises one edge after
  // accept); acks are honoured only while our own req is high, so stray or
  // late acks fall through every branch untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                <= IDLE;
      pioRegfileRead_addr  <= '0;
      pioRegfileRead_req   <= 1'b0;
      pioRegfileWrite_addr <= '0;
      pioRegfileWrite_data <= '0;
      pioRegfileWrite_req  <= 1'b0;
      rsp_valid            <= 1'b0;
      rsp_rdata            <= '0;
      rsp_write            <= 1'b0;
      rsp_error            <= 1'b0;
      busy                 <= 1'b0;
      err_count            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            busy <= 1'b1;
            if (cmd_write) begin
              state                <= WREQ;
              pioRegfileWrite_addr <= cmd_addr;
              pioRegfileWrite_data <= cmd_wdata;
            end else begin
              state               <= RREQ;
              pioRegfileRead_addr <= cmd_addr;
            end
          end
        end

        WREQ: begin
          if (!pioRegfileWrite_req) begin
            pioRegfileWrite_req <= 1'b1;
          end else if (pioRegfileWrite_ack) begin
            pioRegfileWrite_req <= 1'b0;
            state               <= RSP;
            rsp_valid           <= 1'b1;
            rsp_rdata           <= ERR_RDATA;
            rsp_write           <= 1'b1;
            rsp_error           <= 1'b0;
          end else if (expired) begin
            pioRegfileWrite_req <= 1'b0;
            state               <= RSP;
            rsp_valid           <= 1'b1;
            rsp_rdata           <= ERR_RDATA;
            rsp_write           <= 1'b1;
            rsp_error           <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERRW'(1);
          end
        end

        RREQ: begin
          if (!pioRegfileRead_req) begin
            pioRegfileRead_req <= 1'b1;
          end else if (pioRegfileRead_ack) begin
            pioRegfileRead_req <= 1'b0;
            state              <= RSP;
            rsp_valid          <= 1'b1;
            rsp_rdata          <= pioRegfileRead_return;
            rsp_write          <= 1'b0;
            rsp_error          <= 1'b0;
          end else if (expired) begin
            pioRegfileRead_req <= 1'b0;
            state              <= RSP;
            rsp_valid          <= 1'b1;
            rsp_rdata          <= ERR_RDATA;
            rsp_write          <= 1'b0;
            rsp_error          <= 1'b1;
            if (err_count != '1) err_count <= err_count + ERRW'(1);
          end
        end

        RSP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_hsimple_master.sv
module tb_pio_hsimple_master;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0, cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_error;
  logic [31:0] rsp_rdata;
  logic [31:0] rdAddr, rdReturn = '0, wrAddr, wrData;
  logic        rdReq, rdAck = 1'b0, wrReq, wrAck = 1'b0;
  logic        busy;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;
  int expErr = 0;

  // Slave register file model: written on accepted write acks only.
  logic [31:0] mem [logic [31:0]];

  always #5 clk = ~clk;

  pio_hsimple_master #(.TIMEOUT_CYCLES(TO), .ERRW(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .cmd_valid             (cmd_valid),
    .cmd_ready             (cmd_ready),
    .cmd_write             (cmd_write),
    .cmd_addr              (cmd_addr),
    .cmd_wdata             (cmd_wdata),
    .rsp_valid             (rsp_valid),
    .rsp_ready             (rsp_ready),
    .rsp_rdata             (rsp_rdata),
    .rsp_write             (rsp_write),
    .rsp_error             (rsp_error),
    .pioRegfileRead_addr   (rdAddr),
    .pioRegfileRead_req    (rdReq),
    .pioRegfileRead_ack    (rdAck),
    .pioRegfileRead_return (rdReturn),
    .pioRegfileWrite_addr  (wrAddr),
    .pioRegfileWrite_data  (wrData),
    .pioRegfileWrite_req   (wrReq),
    .pioRegfileWrite_ack   (wrAck),
    .busy                  (busy),
    .err_count             (err_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] slaveRd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a * 32'd3 + 32'h1000_0001);
  endfunction

  // One full command/response transaction.
  // ackDly: slave acks ackDly cycles after req rises (ack held in req-high
  // cycle ackDly+1); ackDly<0 or ackDly>=TO means the timeout fires first.
  // bp: cycles rsp_ready is held low once the response is visible.
  // stray: pulse the port's ack while its req is still low.
  task automatic txn(input bit wr, input logic [31:0] a, input logic [31:0] d,
                     input int ackDly, input int bp, input bit stray, input string tag);
    int w = 0, cyc = 0, hi = 0;
    bit tmo, curReq, othReq, doAck;
    logic [31:0] expRd;
    while (!cmd_ready && w < 20) begin tick; w++; end
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    tmo   = !(ackDly >= 0 && ackDly < TO);
    expRd = (wr || tmo) ? 32'd0 : slaveRd(a);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    tick;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
    chk({tag, " req_after_accept"}, 32'(wr ? wrReq : rdReq), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    while (!rsp_valid && cyc < TO + 8) begin
      curReq = wr ? wrReq : rdReq;
      othReq = wr ? rdReq : wrReq;
      chk({tag, " other_req"}, 32'(othReq), 32'd0);
      if (curReq) begin
        hi++;
        chk({tag, " addr_hold"}, wr ? wrAddr : rdAddr, a);
        if (wr) chk({tag, " data_hold"}, wrData, d);
      end
      doAck = curReq && !tmo && (hi == ackDly + 1);
      if (wr) wrAck = doAck || (stray && !curReq);
      else    rdAck = doAck || (stray && !curReq);
      rdReturn = (doAck && !wr) ? expRd : 32'($urandom);
      if (doAck && wr) mem[a] = d;
      tick;
      cyc++;
      rdAck = 1'b0; wrAck = 1'b0;
    end
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " req_high_cycles"}, 32'(hi), 32'(tmo ? TO : ackDly + 1));
    chk({tag, " latency"}, 32'(cyc), 32'(hi + 1));
    chk({tag, " req_dropped"}, 32'({wrReq, rdReq}), 32'd0);
    if (tmo) expErr++;
    chk({tag, " rsp_error"}, 32'(rsp_error), 32'(tmo));
    chk({tag, " rsp_write"}, 32'(rsp_write), 32'(wr));
    chk({tag, " rsp_rdata"}, rsp_rdata, expRd);
    chk({tag, " err_count"}, 32'(err_count), 32'(expErr));
    for (int i = 0; i < bp; i++) begin
      tick;
      chk({tag, " bp_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, " bp_rdata"}, rsp_rdata, expRd);
      chk({tag, " bp_error"}, 32'(rsp_error), 32'(tmo));
      chk({tag, " bp_cmd_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    chk({tag, " rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({tag, " idle_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset values while reset is held low.
    #12;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst reqs", 32'({rdReq, wrReq}), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst err_count", 32'(err_count), 32'd0);
    chk("rst rsp_fields", 32'({rsp_rdata != 0, rsp_error, rsp_write}), 32'd0);
    chk("rst addrs", rdAddr | wrAddr | wrData, 32'd0);
    @(negedge clk); reset = 1'b1;
    tick;
    chk("post_rst cmd_ready", 32'(cmd_ready), 32'd1);

    // Basic write: ack two cycles after req rises -> req high 3 cycles.
    txn(1'b1, 32'd8, 32'hdeadbeef, 2, 0, 1'b0, "wr8");

    // Read-back ordering.
    txn(1'b1, 32'd16, 32'h12345678, 0, 0, 1'b0, "wr16");
    txn(1'b0, 32'd8,  32'd0, 1, 0, 1'b0, "rd8");
    chk("rd8 value", rsp_rdata, 32'hdeadbeef);
    txn(1'b0, 32'd16, 32'd0, 0, 0, 1'b1, "rd16");
    chk("rd16 value", rsp_rdata, 32'h12345678);

    // Timeout, then a late ack that must be ignored.
    txn(1'b0, 32'd24, 32'd0, -1, 0, 1'b0, "tmo24");
    tick; tick;
    rdAck = 1'b1; rdReturn = 32'hbad0bad0;
    tick;
    rdAck = 1'b0;
    chk("late_ack rsp_valid", 32'(rsp_valid), 32'd0);
    chk("late_ack busy", 32'(busy), 32'd0);
    chk("late_ack req", 32'(rdReq), 32'd0);
    chk("late_ack err_count", 32'(err_count), 32'd1);

    // Backpressure, followed by an immediately accepted command.
    txn(1'b0, 32'd8, 32'd0, 0, 10, 1'b0, "bp_rd8");
    chk("bp next_ready", 32'(cmd_ready), 32'd1);
    txn(1'b1, 32'd40, 32'h0badcafe, 1, 0, 1'b0, "bp_next");

    // Ack exactly on the timeout edge: ack wins.
    txn(1'b0, 32'd16, 32'd0, TO - 1, 0, 1'b0, "collide");
    chk("collide value", rsp_rdata, 32'h12345678);

    // Randomized traffic against the model.
    for (int n = 0; n < 24; n++) begin
      bit wrR;
      logic [31:0] aR;
      wrR = 1'($urandom_range(0, 1));
      aR  = 32'($urandom_range(1, 6) * 8);
      txn(wrR, aR, 32'($urandom), int'($urandom_range(0, TO + 1)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
    end

    // Mid-transaction reset.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'd48;
    tick;
    cmd_valid = 1'b0;
    tick;
    chk("midrst req_before", 32'(rdReq), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst req", 32'(rdReq), 32'd0);
    chk("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst err_count", 32'(err_count), 32'd0);
    chk("midrst addr", rdAddr, 32'd0);
    expErr = 0;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("midrst no_rsp", 32'({rsp_valid, rdReq, busy}), 32'd0);
    end
    txn(1'b1, 32'd8, 32'h5a5a1234, 0, 1, 1'b0, "post_rst_wr");
    txn(1'b0, 32'd8, 32'd0, 2, 0, 1'b0, "post_rst_rd");
    chk("post_rst_rd value", rsp_rdata, 32'h5a5a1234);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
